// File: rtl/tcb_femto_bridge.sv
// Registered bridge from a FemtoRV32-style memory port to a single TCB manager port.
// Handles rdy backpressure, fixed read latency, bus-error capture and a rdy timeout.
module tcb_femto_bridge #(
  parameter int unsigned    AW       = 22,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    BW       = DW/8,
  parameter int unsigned    RLAT     = 1,
  parameter int unsigned    TMO      = 256,
  parameter logic [DW-1:0]  ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wmask,
  input  logic          mem_rstrb,
  output logic [31:0]   mem_rdata,
  output logic          mem_rbusy,
  output logic          mem_wbusy,
  output logic          tcb_vld,
  output logic          tcb_wen,
  output logic [AW-1:0] tcb_adr,
  output logic [BW-1:0] tcb_ben,
  output logic [DW-1:0] tcb_wdt,
  input  logic          tcb_rdy,
  input  logic [DW-1:0] tcb_rdt,
  input  logic          tcb_err,
  output logic          err,
  output logic          viol,
  output logic [7:0]    err_cnt
);

  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  generate
    if (DW != 32 || RLAT > 2) begin : g_bad_param
      $error("tcb_femto_bridge: DW must be 32 and RLAT must be 0..2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t         state;
  logic [TW-1:0]  wait_cnt;
  logic [1:0]     lat_cnt;
  logic           wr_req;
  logic           strobe;
  logic           unused_addr;

  assign wr_req      = |mem_wmask;
  assign strobe      = mem_rstrb | wr_req;
  assign unused_addr = ^mem_addr;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Request FSM: captures core requests, drives TCB, collects the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_cnt   <= 2'd0;
      tcb_vld   <= 1'b0;
      tcb_wen   <= 1'b0;
      tcb_adr   <= '0;
      tcb_ben   <= '0;
      tcb_wdt   <= '0;
      mem_rdata <= 32'h0000_0000;
      mem_rbusy <= 1'b0;
      mem_wbusy <= 1'b0;
      err       <= 1'b0;
      viol      <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            tcb_adr   <= mem_addr[AW-1:0];
            tcb_wdt   <= mem_wdata;
            tcb_ben   <= wr_req ? mem_wmask : {BW{1'b1}};
            tcb_wen   <= wr_req;
            tcb_vld   <= 1'b1;
            mem_rbusy <= ~wr_req;
            mem_wbusy <= wr_req;
            wait_cnt  <= '0;
            state     <= REQ;
            // simultaneous read and write strobes: the write is kept
            if (mem_rstrb && wr_req) begin
              viol <= 1'b1;
            end
          end
        end
        REQ: begin
          if (strobe) begin
            viol <= 1'b1;
          end
          if (tcb_rdy) begin
            tcb_vld <= 1'b0;
            if (tcb_wen) begin
              mem_wbusy <= 1'b0;
              state     <= IDLE;
              if (tcb_err) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
              end
            end else if (RLAT == 0) begin
              mem_rdata <= tcb_err ? ERR_DATA : tcb_rdt;
              mem_rbusy <= 1'b0;
              state     <= IDLE;
              if (tcb_err) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
              end
            end else begin
              lat_cnt <= 2'(RLAT);
              state   <= RSP;
            end
          end else if (TMO != 0 && wait_cnt == TW'(TMO - 1)) begin
            tcb_vld   <= 1'b0;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
            err       <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state     <= IDLE;
            if (!tcb_wen) begin
              mem_rdata <= ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RSP: begin
          if (strobe) begin
            viol <= 1'b1;
          end
          // read data arrives RLAT cycles after the transfer
          if (lat_cnt == 2'd1) begin
            mem_rdata <= tcb_err ? ERR_DATA : tcb_rdt;
            mem_rbusy <= 1'b0;
            state     <= IDLE;
            if (tcb_err) begin
              err     <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          state   <= IDLE;
          tcb_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcb_femto_bridge.sv
// Randomized bench for tcb_femto_bridge: per-transaction timing/data model driven
// by a cycle-indexed TCB subordinate, plus directed reset, timeout and violation cases.
module tb_tcb_femto_bridge;

  localparam int AW   = 22;
  localparam int RLAT = 1;
  localparam int TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          clk;
  logic          rst;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rstrb;
  logic [31:0]   mem_rdata;
  logic          mem_rbusy;
  logic          mem_wbusy;
  logic          tcb_vld;
  logic          tcb_wen;
  logic [AW-1:0] tcb_adr;
  logic [3:0]    tcb_ben;
  logic [31:0]   tcb_wdt;
  logic          tcb_rdy;
  logic [31:0]   tcb_rdt;
  logic          tcb_err;
  logic          err;
  logic          viol;
  logic [7:0]    err_cnt;

  int checks = 0;
  int failures = 0;

  // reference state of the sticky/held outputs
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_viol;
  int          m_cnt;

  tcb_femto_bridge #(.AW(AW), .RLAT(RLAT), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .tcb_vld(tcb_vld), .tcb_wen(tcb_wen),
    .tcb_adr(tcb_adr), .tcb_ben(tcb_ben), .tcb_wdt(tcb_wdt),
    .tcb_rdy(tcb_rdy), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
    .err(err), .viol(viol), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sticky(input string tag);
    chk({tag, ".rdata"}, mem_rdata, m_rdata);
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".viol"}, 32'(viol), 32'(m_viol));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
  endtask

  // One core transaction. dly = rdy-low cycles before the transfer; dly >= TMO times out.
  task automatic run_op(input string tag, input logic rd, input logic [3:0] wm,
                        input logic [31:0] adr, input logic [31:0] wdt, input int dly,
                        input logic e, input logic [31:0] rdv, input logic inj);
    logic       is_wr;
    logic       tmo;
    int         xfer, vld_end, done, smp;
    logic [3:0] exp_ben;
    is_wr   = (wm != 4'h0);
    tmo     = (dly >= TMO);
    xfer    = 1 + dly;
    vld_end = tmo ? TMO : xfer;
    done    = tmo ? TMO + 1 : (is_wr ? xfer + 1 : xfer + RLAT + 1);
    smp     = is_wr ? xfer : xfer + RLAT;
    exp_ben = is_wr ? wm : 4'hF;
    for (int c = 0; c <= done; c++) begin
      if (c > 0) begin
        step();
        if (c == 1 && rd && is_wr) m_viol = 1'b1;
        if (c == 2 && inj) m_viol = 1'b1;
        if (c == done) begin
          if (tmo || e) begin
            m_err = 1'b1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          end
          if (!is_wr) m_rdata = (tmo || e) ? ERRD : rdv;
        end
        chk({tag, ".vld"}, 32'(tcb_vld), 32'(c <= vld_end));
        chk({tag, ".rbusy"}, 32'(mem_rbusy), 32'(!is_wr && c < done));
        chk({tag, ".wbusy"}, 32'(mem_wbusy), 32'(is_wr && c < done));
        if (c <= vld_end) begin
          chk({tag, ".adr"}, 32'(tcb_adr), 32'(adr[AW-1:0]));
          chk({tag, ".ben"}, 32'(tcb_ben), 32'(exp_ben));
          chk({tag, ".wen"}, 32'(tcb_wen), 32'(is_wr));
          chk({tag, ".wdt"}, tcb_wdt, wdt);
        end
        chk_sticky(tag);
      end
      mem_rstrb = (c == 0) ? rd : (inj && c == 1);
      mem_wmask = (c == 0) ? wm : 4'h0;
      mem_addr  = (c == 0) ? adr : $urandom;
      mem_wdata = (c == 0) ? wdt : $urandom;
      tcb_rdy   = (c >= 1 && c <= vld_end) ? (!tmo && c == xfer) : 1'($urandom);
      tcb_rdt   = (!is_wr && !tmo && c == smp) ? rdv : $urandom;
      tcb_err   = (!tmo && c == smp) ? e : 1'($urandom);
    end
    step();
    chk({tag, ".idle_vld"}, 32'(tcb_vld), 32'd0);
    chk({tag, ".idle_busy"}, 32'({mem_rbusy, mem_wbusy}), 32'd0);
    chk_sticky({tag, ".idle"});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vld"}, 32'(tcb_vld), 32'd0);
    chk({tag, ".busy"}, 32'({mem_rbusy, mem_wbusy}), 32'd0);
    chk({tag, ".tcb"}, 32'({tcb_wen, tcb_ben, tcb_adr}), 32'd0);
    chk({tag, ".wdt"}, tcb_wdt, 32'd0);
    chk_sticky(tag);
  endtask

  initial begin
    rst = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
    tcb_rdy = 1'b0; tcb_rdt = 32'd0; tcb_err = 1'b0;
    m_rdata = 32'd0; m_err = 1'b0; m_viol = 1'b0; m_cnt = 0;
    repeat (3) step();
    chk_reset("reset");
    #2 rst = 1'b1;
    step();

    run_op("rd_basic", 1'b1, 4'h0, 32'h0000_1234, 32'h0, 0, 1'b0, 32'h12345678, 1'b0);
    run_op("wr_byte", 1'b0, 4'b0100, 32'h0020_0010, 32'h00AB_0000, 3, 1'b0, 32'h0, 1'b0);
    run_op("rd_tmo", 1'b1, 4'h0, 32'h0000_0040, 32'h0, 1000, 1'b0, 32'h0, 1'b0);
    run_op("rd_last_wait", 1'b1, 4'h0, 32'h0000_0044, 32'h0, TMO - 1, 1'b0, 32'hCAFE_F00D, 1'b0);
    run_op("wr_tmo", 1'b0, 4'hF, 32'h0000_0048, 32'h5555_AAAA, TMO, 1'b0, 32'h0, 1'b0);
    run_op("rd_buserr", 1'b1, 4'h0, 32'h0000_004C, 32'h0, 1, 1'b1, 32'h0BAD_0BAD, 1'b0);
    run_op("wr_buserr", 1'b0, 4'h3, 32'h0000_0050, 32'h1111_2222, 0, 1'b1, 32'h0, 1'b0);
    run_op("rd_after_err", 1'b1, 4'h0, 32'h0000_0054, 32'h0, 0, 1'b0, 32'h7654_3210, 1'b0);
    run_op("viol_both", 1'b1, 4'hF, 32'h0000_0058, 32'h9999_8888, 0, 1'b0, 32'h0, 1'b0);
    run_op("viol_busy", 1'b1, 4'h0, 32'h0000_005C, 32'h0, 2, 1'b0, 32'hA5A5_5A5A, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic       w, r, e, inj;
      logic [3:0] wm;
      int         k, dly;
      w   = 1'($urandom);
      wm  = w ? 4'($urandom_range(1, 15)) : 4'h0;
      r   = w ? ($urandom_range(0, 7) == 0) : 1'b1;
      k   = $urandom_range(0, 9);
      dly = (k < 7) ? k % 4 : ((k == 9) ? TMO : TMO - 1);
      e   = ($urandom_range(0, 3) == 0);
      inj = ($urandom_range(0, 5) == 0);
      run_op("rand", r, wm, $urandom, $urandom, dly, e, $urandom, inj);
    end

    // reset while the read waits for its data
    mem_rstrb = 1'b1; mem_addr = 32'h0000_0100; tcb_rdy = 1'b0;
    step();
    mem_rstrb = 1'b0; tcb_rdy = 1'b1;
    step();
    tcb_rdy = 1'b0; tcb_rdt = 32'h3333_4444; tcb_err = 1'b0;
    chk("rst_mid.rbusy_before", 32'(mem_rbusy), 32'd1);
    #2 rst = 1'b0;
    #1;
    m_rdata = 32'd0; m_err = 1'b0; m_viol = 1'b0; m_cnt = 0;
    chk_reset("rst_mid");
    #2 rst = 1'b1;
    step();
    chk_reset("rst_mid.after");
    run_op("rd_post_rst", 1'b1, 4'h0, 32'h0000_0104, 32'h0, 0, 1'b0, 32'h1357_9BDF, 1'b0);

    for (int i = 0; i < 300; i++) begin
      run_op("rd_err_sat", 1'b1, 4'h0, $urandom, 32'h0, 0, 1'b1, $urandom, 1'b0);
    end
    chk("err_cnt_final", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcb_femto_bridge.md
Name: tcb_femto_bridge

Overview:
- Registered bridge between a FemtoRV32-style memory port (rstrb/wmask/rbusy/wbusy) and one TCB load/store manager port.
- Replaces the zero-wait-state combinational glue used in core testbenches.
- Supports TCB backpressure (rdy), configurable read-data latency, bus-error capture and a response timeout.
- Sits between the core and the TCB address decoder.

Parameters:
- AW, 22: TCB address width; the bridge forwards mem_addr[AW-1:0].
- DW, 32: data width, fixed to 32 for this core family; checked at elaboration.
- BW, DW/8: byte-enable width.
- RLAT, 1: TCB read-data latency in cycles after the vld&rdy transfer; legal range 0..2.
- TMO, 256: maximum cycles spent waiting for rdy before abort; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timeout or bus error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mem_addr  in  32  core address
- mem_wdata  in  32  core write data
- mem_wmask  in  4  core byte write mask; nonzero for one cycle starts a write
- mem_rstrb  in  1  one-cycle pulse that starts a read
- mem_rdata  out  32  read data, held until the next read completes
- mem_rbusy  out  1  read in progress
- mem_wbusy  out  1  write in progress
- tcb_vld  out  1  TCB request valid
- tcb_wen  out  1  TCB write enable
- tcb_adr  out  AW  TCB address
- tcb_ben  out  BW  TCB byte enables
- tcb_wdt  out  DW  TCB write data
- tcb_rdy  in  1  TCB ready
- tcb_rdt  in  DW  TCB read data
- tcb_err  in  1  TCB response error, sampled with tcb_rdt (reads) or at the transfer (writes)
- err  out  1  sticky flag: bus error or timeout
- viol  out  1  sticky flag: protocol violation on the core side
- err_cnt  out  8  saturating count of errored or timed-out transfers

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs to 0: state IDLE, tcb_vld=0, mem_rbusy=0, mem_wbusy=0, mem_rdata=0, err=0, viol=0, err_cnt=0. A transfer in flight is dropped; no response is returned after reset.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - On mem_rstrb or |mem_wmask, capture adr, wdt, ben and wen into request registers.
  - ben = mem_wmask for a write, all ones for a read.
  - Go to REQ.
  - If mem_rstrb and |mem_wmask are both set, the write wins and viol is set.
- Busy flags:
  - mem_rbusy=1 in REQ and RSP when the captured op is a read.
  - mem_wbusy=1 in REQ when the captured op is a write.
  - Both flags assert the cycle after the strobe (registered). The core samples busy the cycle after its strobe.
- REQ:
  - tcb_vld=1, with tcb_* driven only from the request registers.
  - On tcb_vld & tcb_rdy, a write returns to IDLE; wbusy drops the next cycle, so total latency is 2 cycles with rdy=1.
  - On the same transfer, a read with RLAT=0 loads mem_rdata from tcb_rdt and goes to IDLE.
  - A read with RLAT>0 goes to RSP with a latency counter of RLAT.
- RSP:
  - Decrement the counter each cycle; tcb_vld=0.
  - When the counter hits 1, load mem_rdata from tcb_rdt and go to IDLE.
  - Read latency with rdy=1 is RLAT+2 cycles from strobe to rbusy low.
- Timeout:
  - The wait counter counts cycles in REQ with tcb_rdy=0.
  - At TMO the bridge drops tcb_vld, loads mem_rdata=ERR_DATA (reads only), sets err, increments err_cnt and goes to IDLE.
  - The counter clears on entry to REQ.
- Bus error: tcb_err=1 at the response sample sets err and increments err_cnt; for a read, mem_rdata=ERR_DATA.
- err_cnt saturates at 255; it does not wrap.
- A strobe while not IDLE is ignored (no capture) and sets viol.
- Back-to-back transfers: a strobe in the same cycle the FSM returns to IDLE is not accepted. The core guarantees this by waiting for busy low.
- tcb_* outputs hold stable while tcb_vld=1 && !tcb_rdy.

Test Plan:
- Read, RLAT=1, rdy=1, rdt=32'h12345678: rstrb at T -> vld at T+1; rbusy high T+1..T+2, low T+3; mem_rdata=32'h12345678 from T+3.
- Write byte: wmask=4'b0100, addr 0x200010, wdata 0x00AB0000, rdy held 0 for 3 cycles -> vld/adr/ben/wdt stable 4 cycles, one transfer with wen=1 ben=0100, wbusy low the cycle after the transfer.
- Timeout, TMO=8, rdy=0 forever on a read -> vld drops after 8 wait cycles; mem_rdata=32'hDEADBEEF, err=1, err_cnt=1, rbusy low.
- Bus error on a read with tcb_err=1 -> mem_rdata=ERR_DATA, err=1, err_cnt increments; 300 errored reads -> err_cnt=255.
- Violations: rstrb and wmask=4'hF together -> one write, viol=1; rstrb while busy -> no second transfer, viol=1.
- Reset asserted while in RSP -> all outputs 0 immediately; a subsequent read completes normally with correct data.
